// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and control states for alu_seq.
// The multiply opcode is decoded only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IDT = 4'b1100;
    localparam logic [3:0] OP_NON = 4'b1111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial-product bit per cycle.
// Only compiled when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      cnt;

    // product is the accumulator after this cycle's step; it is final when done is high
    assign product = acc + (b_sh[0] ? a_sh : '0);
    assign done    = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (start) begin
            a_sh <= {{WIDTH{1'b0}}, a};
            b_sh <= b;
            acc  <= '0;
            cnt  <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc  <= product;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CW'(1);
        end
    end
endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides and registered result/flags.
// ALU_SEQ_MUL_EN adds the multi-cycle unsigned multiply; otherwise 0101 acts as NON.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    input  logic [3:0]       S_ALU,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [3:0]       FLAG_OUT,
    output logic             BUSY
);
    localparam logic [SHW:0] W_EXT = (SHW+1)'(WIDTH);

    state_t state, state_nxt;
    logic   accept;
    logic   is_mul;

    function automatic logic [WIDTH+3:0] pack(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f[FLAG_S] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return {f, r};
    endfunction

    function automatic logic [WIDTH+3:0] alu_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0]     wide;
        logic [2*WIDTH-1:0] rot;
        logic [SHW-1:0]     amt;
        logic [SHW:0]       hi_idx;
        logic [SHW-1:0]     lo_idx;
        logic [WIDTH-1:0]   r;
        logic               c;
        logic               v;
        amt    = b[SHW-1:0];
        hi_idx = W_EXT - {1'b0, amt};
        lo_idx = amt - SHW'(1);
        wide   = '0;
        rot    = '0;
        r      = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_IDT: r = a;
            OP_SLL: begin
                r = a << amt;
                c = (amt != '0) && a[hi_idx[SHW-1:0]];
            end
            OP_ROL: begin
                rot = {a, a} << amt;
                r   = rot[2*WIDTH-1:WIDTH];
                c   = (amt != '0) && r[0];
            end
            OP_SRL: begin
                r = a >> amt;
                c = (amt != '0) && a[lo_idx];
            end
            OP_SRA: begin
                r = $signed(a) >>> amt;
                c = (amt != '0) && a[lo_idx];
            end
            default: r = '0;
        endcase
        return pack(r, c, v);
    endfunction

    assign accept = IN_VALID && IN_READY;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul = (S_ALU == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (CLK),
        .rst     (RST),
        .start   (accept && is_mul),
        .a       (DATA_A),
        .b       (DATA_B),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= alu_seq_pkg::IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            alu_seq_pkg::IDLE:
                if (accept) state_nxt = is_mul ? alu_seq_pkg::BUSY : alu_seq_pkg::DONE;
`ifdef ALU_SEQ_MUL_EN
            alu_seq_pkg::BUSY:
                if (mul_done) state_nxt = alu_seq_pkg::DONE;
`endif
            alu_seq_pkg::DONE:
                if (accept)         state_nxt = is_mul ? alu_seq_pkg::BUSY : alu_seq_pkg::DONE;
                else if (OUT_READY) state_nxt = alu_seq_pkg::IDLE;
            default: state_nxt = alu_seq_pkg::IDLE;
        endcase
    end

    // IN_READY deliberately ignores IN_VALID so upstream can't form a loop through it
    always_comb begin
        IN_READY  = !RST && ((state == alu_seq_pkg::IDLE) ||
                             ((state == alu_seq_pkg::DONE) && OUT_READY));
        OUT_VALID = (state == alu_seq_pkg::DONE);
`ifdef ALU_SEQ_MUL_EN
        BUSY      = (state == alu_seq_pkg::BUSY);
`else
        BUSY      = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_OUT  <= '0;
            FLAG_OUT <= '0;
        end else if (accept && !is_mul) begin
            {FLAG_OUT, ALU_OUT} <= alu_op(S_ALU, DATA_A, DATA_B);
        end
`ifdef ALU_SEQ_MUL_EN
        else if ((state == alu_seq_pkg::BUSY) && mul_done) begin
            {FLAG_OUT, ALU_OUT} <= pack(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
        end
`endif
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed scenarios plus randomized ops
// against an arithmetic reference model. Honors ALU_SEQ_MUL_EN like the design.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic [3:0]   s_alu = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] alu_out;
    logic [3:0]   flag_out;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .DATA_A(data_a), .DATA_B(data_b), .S_ALU(s_alu), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .ALU_OUT(alu_out), .FLAG_OUT(flag_out), .BUSY(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    // Reference: {S,Z,C,V,result} from plain integer arithmetic
    function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int     amt;
        longint full;
        int     sa, sb, ss;
        logic [W-1:0] r;
        logic c, v;
        amt = int'(b[3:0]);
        sa = int'($signed(a));
        sb = int'($signed(b));
        full = 0; ss = 0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: begin
                full = longint'(a) + longint'(b); r = full[W-1:0]; c = (full > 65535);
                ss = sa + sb; v = (ss > 32767) || (ss < -32768);
            end
            4'h1: begin
                full = longint'(a) - longint'(b); r = full[W-1:0]; c = (a < b);
                ss = sa - sb; v = (ss > 32767) || (ss < -32768);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
`ifdef ALU_SEQ_MUL_EN
            4'h5: begin
                full = longint'(a) * longint'(b); r = full[W-1:0]; c = ((full >> 16) != 0);
            end
`endif
            4'h8: begin
                full = longint'(a) << amt; r = full[W-1:0];
                c = (amt > 0) ? ((a >> (16 - amt)) & 16'h1) != 0 : 1'b0;
            end
            4'h9: begin
                full = (longint'(a) << amt) | (longint'(a) >> (16 - amt)); r = full[W-1:0];
                c = (amt > 0) ? r[0] : 1'b0;
            end
            4'hA: begin
                r = a >> amt; c = (amt > 0) ? ((a >> (amt - 1)) & 16'h1) != 0 : 1'b0;
            end
            4'hB: begin
                ss = sa >>> amt; r = ss[W-1:0];
                c = (amt > 0) ? ((a >> (amt - 1)) & 16'h1) != 0 : 1'b0;
            end
            4'hC: r = a;
            default: r = '0;
        endcase
        return {r[W-1], (r == 0), c, v, r};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests++;
        if ({out_valid, busy, flag_out, alu_out} !== '0) begin
            fails++; $display("FAIL reset_outputs: got ov=%b busy=%b flag=%b out=%h want all 0", out_valid, busy, flag_out, alu_out);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; s_alu = 4'h0; data_a = 16'h7FFF; data_b = 16'h0001; out_ready = 1'b1;
        @(negedge clk);
        tests++; if ({out_valid, flag_out, alu_out} !== {1'b1, 4'b1001, 16'h8000}) begin
            fails++; $display("FAIL add_ovf: got ov=%b flag=%b out=%h want 1 1001 8000", out_valid, flag_out, alu_out); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        s_alu = 4'h1; data_a = 16'h0003; data_b = 16'h0005;
        @(negedge clk);
        tests++; if ({out_valid, flag_out, alu_out} !== {1'b1, 4'b1010, 16'hFFFE}) begin
            fails++; $display("FAIL sub_borrow: got ov=%b flag=%b out=%h want 1 1010 fffe", out_valid, flag_out, alu_out); end
        s_alu = 4'hB; data_a = 16'h8001; data_b = 16'h0001;
        @(negedge clk);
        tests++; if ({out_valid, flag_out, alu_out} !== {1'b1, 4'b1010, 16'hC000}) begin
            fails++; $display("FAIL sra: got ov=%b flag=%b out=%h want 1 1010 c000", out_valid, flag_out, alu_out); end
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_idle: got ov=%b want 0", out_valid); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; s_alu = 4'h9; data_a = 16'h8001; data_b = 16'h0004; out_ready = 1'b0;
        @(negedge clk);
        s_alu = 4'h4; data_a = 16'hFF00; data_b = 16'h0F0F;
        for (int k = 0; k < 5; k++) begin
            tests++; if ({out_valid, in_ready, flag_out, alu_out} !== {1'b1, 1'b0, 4'b0000, 16'h0018}) begin
                fails++; $display("FAIL rol_hold[%0d]: got ov=%b rdy=%b flag=%b out=%h want 1 0 0000 0018",
                                  k, out_valid, in_ready, flag_out, alu_out); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        tests++; if ({out_valid, flag_out, alu_out} !== {1'b1, 4'b1000, 16'hF00F}) begin
            fails++; $display("FAIL xor_after_stall: got ov=%b flag=%b out=%h want 1 1000 f00f", out_valid, flag_out, alu_out); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_done();
        in_valid = 1'b1; s_alu = 4'h0; data_a = 16'h0001; data_b = 16'h0001; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        tests++; if ({out_valid, in_ready, flag_out, alu_out} !== '0) begin
            fails++; $display("FAIL rst_in_done: got ov=%b rdy=%b flag=%b out=%h want all 0", out_valid, in_ready, flag_out, alu_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        int busy_cnt, lat;
        in_valid = 1'b1; s_alu = 4'h5; data_a = 16'h0100; data_b = 16'h0100; out_ready = 1'b1;
        busy_cnt = 0; lat = 0;
        do begin
            @(negedge clk); in_valid = 1'b0; lat++;
            if (!out_valid) begin
                busy_cnt += int'(busy);
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mul_ready_low[%0d]: got %b want 0", lat, in_ready); end
            end
        end while (!out_valid && lat < 40);
        tests++; if (lat !== 17) begin fails++; $display("FAIL mul_latency: got %0d want 17", lat); end
        tests++; if (busy_cnt !== 16) begin fails++; $display("FAIL mul_busy_cycles: got %0d want 16", busy_cnt); end
        tests++; if ({flag_out, alu_out} !== {4'b0110, 16'h0000}) begin
            fails++; $display("FAIL mul_wrap: got flag=%b out=%h want 0110 0000", flag_out, alu_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_mul();
        logic seen;
        in_valid = 1'b1; s_alu = 4'h5; data_a = 16'h1234; data_b = 16'h5678; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if ({out_valid, busy, flag_out, alu_out} !== '0) begin
            fails++; $display("FAIL rst_in_mul: got ov=%b busy=%b flag=%b out=%h want all 0", out_valid, busy, flag_out, alu_out); end
        rst = 1'b0; seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= out_valid | busy; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_mul_residue: got activity=%b want 0", seen); end
        in_valid = 1'b1; s_alu = 4'h2; data_a = 16'hF0F0; data_b = 16'h0FF0;
        @(negedge clk); in_valid = 1'b0;
        tests++; if ({out_valid, flag_out, alu_out} !== {1'b1, 4'b0000, 16'h00F0}) begin
            fails++; $display("FAIL and_after_rst: got ov=%b flag=%b out=%h want 1 0000 00f0", out_valid, flag_out, alu_out); end
        @(negedge clk);
    endtask
`else
    task automatic test_mul_disabled();
        in_valid = 1'b1; s_alu = 4'h5; data_a = 16'h0003; data_b = 16'h0005; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        tests++; if ({out_valid, busy, flag_out, alu_out} !== {1'b1, 1'b0, 4'b0100, 16'h0000}) begin
            fails++; $display("FAIL mul_as_non: got ov=%b busy=%b flag=%b out=%h want 1 0 0100 0000", out_valid, busy, flag_out, alu_out); end
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W+3:0] exp;
        int lat, exp_lat, stall;
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom); b = 16'($urandom);
            if (i % 8 == 0) b = '0;
            if (i % 8 == 1) b = {12'($urandom), 4'h0};
            exp = model(op, a, b);
`ifdef ALU_SEQ_MUL_EN
            exp_lat = (op == 4'h5) ? 17 : 1;
`else
            exp_lat = 1;
`endif
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rnd_ready[%0d]: got %b want 1", i, in_ready); end
            in_valid = 1'b1; s_alu = op; data_a = a; data_b = b; out_ready = 1'b0;
            lat = 0;
            do begin
                @(negedge clk); in_valid = 1'b0; data_a = 16'($urandom); data_b = 16'($urandom); lat++;
            end while (!out_valid && lat < 40);
            tests++; if (lat !== exp_lat) begin fails++; $display("FAIL rnd_latency[%0d] op=%h: got %0d want %0d", i, op, lat, exp_lat); end
            tests++; if ({flag_out, alu_out} !== exp) begin
                fails++; $display("FAIL rnd_result[%0d] op=%h a=%h b=%h: got %b/%h want %b/%h",
                                  i, op, a, b, flag_out, alu_out, exp[W+3:W], exp[W-1:0]); end
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                tests++; if ({out_valid, in_ready, flag_out, alu_out} !== {1'b1, 1'b0, exp}) begin
                    fails++; $display("FAIL rnd_hold[%0d]: got ov=%b rdy=%b %b/%h want 1 0 %b/%h",
                                      i, out_valid, in_ready, flag_out, alu_out, exp[W+3:W], exp[W-1:0]); end
            end
            out_ready = 1'b1;
            @(negedge clk);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rnd_drain[%0d]: got ov=%b want 0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_reset_in_done();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_reset_in_mul();
`else
        test_mul_disabled();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
